// File: rtl/mmio_pkg.sv
// Shared types and defaults for the MMIO bus fabric.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mmio_state_e;

  localparam logic [31:0] MMIO_ERR_DATA = 32'hDEAD_BEEF;
  localparam logic [7:0]  MMIO_BASE_TAG = 8'hFF;

  // Slot-select field width; a single slot still gets one index bit.
  function automatic int unsigned slot_sel_w(input int unsigned n_slots);
    int unsigned w;
    w = unsigned'($clog2(n_slots));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational address decode: tag/zero-field/range check and one-hot slot select.
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned N_SLOTS  = 6,
  parameter int unsigned REG_AW   = 6,
  parameter logic [7:0]  BASE_TAG = MMIO_BASE_TAG
) (
  input  logic [ADDR_W-1:0]                     addr_i,
  output logic                                  mapped_o,
  output logic [slot_sel_w(N_SLOTS)-1:0]        idx_o,
  output logic [N_SLOTS-1:0]                    onehot_o
);

  localparam int unsigned SEL_W = slot_sel_w(N_SLOTS);
  localparam int unsigned LOW_W = REG_AW + SEL_W;

  logic              tag_ok;
  logic              mid_zero;
  logic              in_range;
  logic [ADDR_W-1:0] mid_bits;

  // Strip the tag from the top and the slot/offset fields from the bottom.
  assign mid_bits = (addr_i << 8) >> (8 + LOW_W);
  assign mid_zero = (mid_bits == '0);
  assign tag_ok   = (addr_i[ADDR_W-1 -: 8] == BASE_TAG);
  assign idx_o    = addr_i[REG_AW +: SEL_W];
  assign in_range = (32'(idx_o) < N_SLOTS);
  assign mapped_o = tag_ok & mid_zero & in_range;
  assign onehot_o = mapped_o ? (N_SLOTS'(1) << idx_o) : '0;

endmodule

// File: rtl/mmio_bus_fabric.sv
// MMIO interconnect: decodes CPU requests to N slots, waits on slot ready with a
// timeout, and completes every transaction with a single registered bus_ready pulse.
module mmio_bus_fabric
  import mmio_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       N_SLOTS  = 6,
  parameter int unsigned       REG_AW   = 6,
  parameter logic [7:0]        BASE_TAG = MMIO_BASE_TAG,
  parameter int unsigned       TIMEOUT  = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(MMIO_ERR_DATA)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           bus_addr,
  input  logic [DATA_W-1:0]           bus_wr_data,
  output logic [DATA_W-1:0]           bus_rd_data,
  input  logic                        bus_cs,
  input  logic                        bus_wr,
  input  logic                        bus_rd,
  output logic                        bus_ready,
  output logic                        bus_err,
  output logic                        err_sticky,
  input  logic                        err_clr,
  output logic [N_SLOTS-1:0]          slot_cs,
  output logic                        slot_wr,
  output logic                        slot_rd,
  output logic [REG_AW-1:0]           slot_addr,
  output logic [DATA_W-1:0]           slot_wr_data,
  input  logic [N_SLOTS*DATA_W-1:0]   slot_rd_data,
  input  logic [N_SLOTS-1:0]          slot_ready
);

  localparam int unsigned SEL_W = slot_sel_w(N_SLOTS);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mmio_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               is_wr_q, is_wr_d;
  logic [N_SLOTS-1:0] slot_cs_q, slot_cs_d;
  logic               slot_wr_q, slot_wr_d;
  logic               slot_rd_q, slot_rd_d;
  logic [REG_AW-1:0]  slot_addr_q, slot_addr_d;
  logic [DATA_W-1:0]  slot_wr_data_q, slot_wr_data_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic               sticky_q, sticky_d;

  logic               dec_mapped;
  logic [SEL_W-1:0]   dec_idx;
  logic [N_SLOTS-1:0] dec_onehot;
  logic               req;
  logic               sel_ready;
  logic [DATA_W-1:0]  sel_data;

  mmio_addr_decode #(
    .ADDR_W   (ADDR_W),
    .N_SLOTS  (N_SLOTS),
    .REG_AW   (REG_AW),
    .BASE_TAG (BASE_TAG)
  ) u_decode (
    .addr_i   (bus_addr),
    .mapped_o (dec_mapped),
    .idx_o    (dec_idx),
    .onehot_o (dec_onehot)
  );

  assign req = bus_cs & (bus_wr | bus_rd);

  // Route only the latched slot's ready and read data; other slots are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int unsigned k = 0; k < N_SLOTS; k++) begin
      if (idx_q == SEL_W'(k)) begin
        sel_ready = slot_ready[k];
        sel_data  = slot_rd_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    is_wr_d        = is_wr_q;
    slot_cs_d      = slot_cs_q;
    slot_wr_d      = slot_wr_q;
    slot_rd_d      = slot_rd_q;
    slot_addr_d    = slot_addr_q;
    slot_wr_data_d = slot_wr_data_q;
    rd_data_d      = rd_data_q;
    ready_d        = 1'b0;
    err_d          = 1'b0;
    sticky_d       = sticky_q & ~err_clr;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          is_wr_d = bus_wr;
          if (dec_mapped) begin
            state_d        = WAIT;
            cnt_d          = '0;
            idx_d          = dec_idx;
            slot_cs_d      = dec_onehot;
            slot_wr_d      = bus_wr;
            slot_rd_d      = ~bus_wr;
            slot_addr_d    = bus_addr[REG_AW-1:0];
            slot_wr_data_d = bus_wr_data;
          end else begin
            state_d   = RESP;
            ready_d   = 1'b1;
            err_d     = 1'b1;
            sticky_d  = 1'b1;
            rd_data_d = bus_wr ? '0 : ERR_DATA;
          end
        end
      end
      WAIT: begin
        // Ready on the last allowed cycle takes priority over the timeout.
        if (sel_ready || (cnt_q == CNT_LAST)) begin
          state_d   = RESP;
          ready_d   = 1'b1;
          slot_cs_d = '0;
          slot_wr_d = 1'b0;
          slot_rd_d = 1'b0;
          if (sel_ready) begin
            rd_data_d = is_wr_q ? '0 : sel_data;
          end else begin
            err_d     = 1'b1;
            sticky_d  = 1'b1;
            rd_data_d = is_wr_q ? '0 : ERR_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      is_wr_q        <= 1'b0;
      slot_cs_q      <= '0;
      slot_wr_q      <= 1'b0;
      slot_rd_q      <= 1'b0;
      slot_addr_q    <= '0;
      slot_wr_data_q <= '0;
      rd_data_q      <= '0;
      ready_q        <= 1'b0;
      err_q          <= 1'b0;
      sticky_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      is_wr_q        <= is_wr_d;
      slot_cs_q      <= slot_cs_d;
      slot_wr_q      <= slot_wr_d;
      slot_rd_q      <= slot_rd_d;
      slot_addr_q    <= slot_addr_d;
      slot_wr_data_q <= slot_wr_data_d;
      rd_data_q      <= rd_data_d;
      ready_q        <= ready_d;
      err_q          <= err_d;
      sticky_q       <= sticky_d;
    end
  end

  assign bus_rd_data  = rd_data_q;
  assign bus_ready    = ready_q;
  assign bus_err      = err_q;
  assign err_sticky   = sticky_q;
  assign slot_cs      = slot_cs_q;
  assign slot_wr      = slot_wr_q;
  assign slot_rd      = slot_rd_q;
  assign slot_addr    = slot_addr_q;
  assign slot_wr_data = slot_wr_data_q;

endmodule

// File: doc/mmio_bus_fabric.md
# mmio_bus_fabric

Parametrised MMIO interconnect between the KLP32 CPU MMIO bus and N peripheral slots, replacing the direct CPU-to-`io_top` hookup. It decodes a slot index from the bus address and drives one-hot slot strobes. It waits on per-slot ready handshakes, registers the read data, and ends every transaction with a single `bus_ready` pulse. Unmapped accesses and slots that do not respond within `TIMEOUT` cycles complete with a bus error instead of hanging the core.

## Interface
Parameters:
- `DATA_W`, 32, data width of CPU and slot buses
- `ADDR_W`, 32, CPU byte-address width
- `N_SLOTS`, 6, number of peripheral slots (1..64)
- `REG_AW`, 6, per-slot register offset bits; slot field is `bus_addr[REG_AW +: SLOT_SEL_W]`, where `SLOT_SEL_W = max(1, $clog2(N_SLOTS))`
- `BASE_TAG`, 8'hFF, required value of `bus_addr[ADDR_W-1 -: 8]`
- `TIMEOUT`, 16, maximum wait cycles for `slot_ready` (≥1)
- `ERR_DATA`, 32'hDEAD_BEEF, read data returned on error

Ports:
- Clock and reset: one clock; reset is synchronous and active-high (ports `clk`, `reset`).
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `bus_addr` in ADDR_W: CPU byte address
- `bus_wr_data` in DATA_W: CPU write data
- `bus_rd_data` out DATA_W: registered read data, valid while `bus_ready`=1
- `bus_cs` in 1: request valid
- `bus_wr` in 1: write request
- `bus_rd` in 1: read request
- `bus_ready` out 1: one-cycle completion pulse
- `bus_err` out 1: qualifies `bus_ready`; the transaction failed
- `err_sticky` out 1: set on any error; cleared by `reset` or `err_clr`
- `err_clr` in 1: clears `err_sticky`
- `slot_cs` out N_SLOTS: one-hot slot select
- `slot_wr`, `slot_rd` out 1: latched request type
- `slot_addr` out REG_AW: latched register offset
- `slot_wr_data` out DATA_W: latched write data
- `slot_rd_data` in N_SLOTS*DATA_W: packed read data; slot k occupies `[k*DATA_W +: DATA_W]`
- `slot_ready` in N_SLOTS: per-slot completion

## Operation
- States: `IDLE`, `WAIT`, `RESP`.
- A request is `bus_cs & (bus_wr | bus_rd)`. It is sampled only in `IDLE`. Requests in any other state are ignored. If `bus_wr` and `bus_rd` are both set, the request is treated as a write.
- In `IDLE`, when a request is sampled, the block latches addr, data and type:
  - The request is mapped if the tag matches `BASE_TAG`, all address bits between the slot field and the tag are zero, and the slot index is less than `N_SLOTS`. Mapped requests go to `WAIT` with timeout counter = 0.
  - Otherwise the request is unmapped: go to `RESP` with error set.
- In `WAIT`:
  - `slot_cs[idx]`, `slot_wr`/`slot_rd`, `slot_addr` and `slot_wr_data` are held stable.
  - If `slot_ready[idx]`=1, capture `slot_rd_data[idx]` (writes capture 0) and go to `RESP` with no error.
  - Else, if counter = `TIMEOUT-1`, go to `RESP` with error. Else increment the counter.
  - Ready on the final cycle wins over timeout.
  - `slot_ready` from non-selected slots is ignored.
- In `RESP`:
  - `bus_ready`=1.
  - `bus_err` reflects the latched error.
  - `bus_rd_data` = captured data, or `ERR_DATA` on an errored read. Errored writes return 0.
  - Next state is `IDLE`.
- `err_sticky` is set on entry to `RESP` with error. If `err_clr` and a new error occur in the same cycle, set wins.
- The counter width is `$clog2(TIMEOUT+1)` and it never wraps.

## Timing
- Reset values: state `IDLE`, `bus_ready`=0, `bus_err`=0, `bus_rd_data`=0, `err_sticky`=0, `slot_cs`=0, `slot_wr`/`slot_rd`=0, `slot_addr`=0, `slot_wr_data`=0.
- Cycle 0 is the request cycle.
  - Mapped request with an immediate ready: strobes active in cycle 1, `bus_ready` in cycle 2.
  - Ready after k wait cycles: `bus_ready` in cycle 2+k.
  - Timeout: `bus_ready` with `bus_err` in cycle `TIMEOUT+1`.
  - Unmapped request: `bus_ready` with `bus_err` in cycle 1, and no slot strobe is ever asserted.
- Earliest next accepted request is the cycle after `bus_ready`. Back-to-back throughput is one transaction per 3 cycles.
- If `reset` is sampled high mid-transaction, all outputs take reset values from the next cycle. No `bus_ready` is issued for the aborted transaction.
- All outputs are registered. The only combinational path is from `slot_ready` and `slot_rd_data` into the capture registers.

## Structure
- `mmio_pkg`: state enum `mmio_state_e`, default `ERR_DATA`, `BASE_TAG`, and a slot-select width function.
- Sub-module `mmio_addr_decode` (combinational): address → `{mapped, idx, onehot}`.
- The FSM, counter and capture registers live in `mmio_bus_fabric`.

## Test plan
- Read `0xFF00_0084`, slot 2 ready in cycle 1, data `0x1234_5678` → `slot_cs`=6'b000100 and `slot_addr`=0x04 in cycle 1; `bus_ready` with `bus_rd_data`=0x1234_5678 and `bus_err`=0 in cycle 2.
- Write `0xFF00_0008` data `0xA5A5_A5A5`, slot 0 ready after 3 cycles → `slot_wr_data`/`slot_wr` held stable through cycles 1–4; `bus_ready` in cycle 5 with `bus_err`=0.
- Read `0xFF00_01C0` (slot 7 ≥ 6) and read `0x0000_0084` (tag mismatch) → no `slot_cs`; `bus_ready`, `bus_err`=1 and `bus_rd_data`=0xDEAD_BEEF in cycle 1; `err_sticky`=1 until `err_clr`.
- Read slot 3, `slot_ready` never asserted, `TIMEOUT`=16 → error response in cycle 17. Repeat with ready arriving exactly in cycle 16 → success, no error.
- A second request asserted during `WAIT`, and `slot_ready` from a non-selected slot → both ignored; exactly one `bus_ready` per accepted request.
- `reset` asserted in cycle 2 of a waiting read → all outputs zero from cycle 3, no `bus_ready`; a fresh read afterwards completes normally.
